// File: rtl/ifm_out_fsm_if.sv
// Handshake bundle for ifm_out_fsm: FWFT FIFO heads, AXI-Stream master, stats.
// master = drain stage side, slave = FIFO / sink / observer side.
interface ifm_out_fsm_if #(
    parameter int C_STAT_WIDTH = 32
);
    logic [7:0]              info_fifo_rdata;
    logic                    info_fifo_empty;
    logic                    info_fifo_rden;
    logic [72:0]             data_fifo_rdata;
    logic                    data_fifo_empty;
    logic                    data_fifo_rden;
    logic [63:0]             m_axis_tdata;
    logic [7:0]              m_axis_tkeep;
    logic                    m_axis_tlast;
    logic                    m_axis_tuser;
    logic                    m_axis_tvalid;
    logic                    m_axis_tready;
    logic [C_STAT_WIDTH-1:0] good_frame_cnt;
    logic [C_STAT_WIDTH-1:0] drop_frame_cnt;
    logic [C_STAT_WIDTH-1:0] good_byte_cnt;
    logic [3:0]              ifm_out_fsm_dbg;

    modport master (
        input  info_fifo_rdata, info_fifo_empty,
        input  data_fifo_rdata, data_fifo_empty,
        input  m_axis_tready,
        output info_fifo_rden, data_fifo_rden,
        output m_axis_tdata, m_axis_tkeep, m_axis_tlast,
        output m_axis_tuser, m_axis_tvalid,
        output good_frame_cnt, drop_frame_cnt, good_byte_cnt,
        output ifm_out_fsm_dbg
    );

    modport slave (
        output info_fifo_rdata, info_fifo_empty,
        output data_fifo_rdata, data_fifo_empty,
        output m_axis_tready,
        input  info_fifo_rden, data_fifo_rden,
        input  m_axis_tdata, m_axis_tkeep, m_axis_tlast,
        input  m_axis_tuser, m_axis_tvalid,
        input  good_frame_cnt, drop_frame_cnt, good_byte_cnt,
        input  ifm_out_fsm_dbg
    );
endinterface

// File: rtl/ifm_out_fsm.sv
// Rx frame drain: pops one info word per frame, then forwards or drops data to tlast.
// Ports: rx_clk, sys_rst (async, active-high), bus (ifm_out_fsm_if.master).
// Stats counters are built only when IFM_OUT_STATS_EN is defined.
module ifm_out_fsm #(
    parameter int C_DROP_BAD   = 1,
    parameter int C_STAT_WIDTH = 32
) (
    input  logic          rx_clk,
    input  logic          sys_rst,
    ifm_out_fsm_if.master bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_DROP = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic        r_good;
    logic        w_info_rden;
    logic        w_data_rden;
    logic        w_last;
    logic        w_push;
    logic        w_pop;
    logic        w_tvalid;
    logic        w_space;
    logic [73:0] w_in;
    // Skid entries: {tuser, tlast, tkeep, tdata}; entry 0 is the head.
    logic [73:0] r_buf0;
    logic [73:0] r_buf1;
    logic [1:0]  r_occ;
    logic        w_unused;

    assign w_unused = &{1'b0, bus.info_fifo_rdata[7:1]};

    assign w_last   = bus.data_fifo_rdata[72];
    assign w_tvalid = (r_occ != 2'd0);
    assign w_pop    = w_tvalid && bus.m_axis_tready;
    assign w_space  = (r_occ != 2'd2) || w_pop;
    assign w_push   = w_data_rden && (r_state == S_FWD);
    assign w_in     = {r_good, bus.data_fifo_rdata};

    always_ff @(posedge rx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_state <= S_IDLE;
            r_good  <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_info_rden)
                r_good <= bus.info_fifo_rdata[0];
        end
    end

    always_comb begin
        w_next      = r_state;
        w_info_rden = 1'b0;
        w_data_rden = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                if (!bus.info_fifo_empty) begin
                    w_info_rden = 1'b1;
                    if (bus.info_fifo_rdata[0] || (C_DROP_BAD == 0))
                        w_next = S_FWD;
                    else
                        w_next = S_DROP;
                end
            end
            S_FWD: begin
                if (!bus.data_fifo_empty && w_space) begin
                    w_data_rden = 1'b1;
                    if (w_last)
                        w_next = S_IDLE;
                end
            end
            S_DROP: begin
                // Discarded words never touch the skid, so no backpressure.
                if (!bus.data_fifo_empty) begin
                    w_data_rden = 1'b1;
                    if (w_last)
                        w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge rx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_buf0 <= '0;
            r_buf1 <= '0;
            r_occ  <= 2'd0;
        end else begin
            unique case ({w_push, w_pop})
                2'b10: begin
                    if (r_occ == 2'd0)
                        r_buf0 <= w_in;
                    else
                        r_buf1 <= w_in;
                    r_occ <= r_occ + 2'd1;
                end
                2'b01: begin
                    r_buf0 <= r_buf1;
                    r_occ  <= r_occ - 2'd1;
                end
                2'b11: begin
                    // Pop implies occ>=1; new word lands behind the survivor.
                    if (r_occ == 2'd1) begin
                        r_buf0 <= w_in;
                    end else begin
                        r_buf0 <= r_buf1;
                        r_buf1 <= w_in;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.info_fifo_rden  = w_info_rden;
    assign bus.data_fifo_rden  = w_data_rden;
    assign bus.m_axis_tvalid   = w_tvalid;
    assign bus.m_axis_tdata    = r_buf0[63:0];
    assign bus.m_axis_tkeep    = r_buf0[71:64];
    assign bus.m_axis_tlast    = r_buf0[72];
    assign bus.m_axis_tuser    = r_buf0[73];
    assign bus.ifm_out_fsm_dbg = {2'b00, r_state};

`ifdef IFM_OUT_STATS_EN
    logic [C_STAT_WIDTH-1:0] r_good_frames;
    logic [C_STAT_WIDTH-1:0] r_drop_frames;
    logic [C_STAT_WIDTH-1:0] r_good_bytes;
    logic [3:0]              w_keep_bytes;

    assign w_keep_bytes = 4'($countones(bus.data_fifo_rdata[71:64]));

    always_ff @(posedge rx_clk or posedge sys_rst) begin
        if (sys_rst) begin
            r_good_frames <= '0;
            r_drop_frames <= '0;
            r_good_bytes  <= '0;
        end else begin
            if (w_data_rden && w_last) begin
                if ((r_state == S_FWD) && r_good)
                    r_good_frames <= r_good_frames + 1'b1;
                else
                    r_drop_frames <= r_drop_frames + 1'b1;
            end
            if (w_push && r_good)
                r_good_bytes <= r_good_bytes + C_STAT_WIDTH'(w_keep_bytes);
        end
    end

    assign bus.good_frame_cnt = r_good_frames;
    assign bus.drop_frame_cnt = r_drop_frames;
    assign bus.good_byte_cnt  = r_good_bytes;
`else
    assign bus.good_frame_cnt = {C_STAT_WIDTH{1'b0}};
    assign bus.drop_frame_cnt = {C_STAT_WIDTH{1'b0}};
    assign bus.good_byte_cnt  = {C_STAT_WIDTH{1'b0}};
`endif
endmodule
